multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 117 +++++++++++
 tb/tb_multicycle_control.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RISC-V control FSM with memory wait timeout and sticky fault
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       fault
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         MEM_ADDR = 4'd4, MEM_RD = 4'd5, MEM_WB = 4'd6, MEM_WR = 4'd7,
                         ALU_WB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11, ERROR = 4'd12;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [3:0] nxt;
  logic [CW-1:0] cnt;
  logic to, tk, bad, req, we, pw, iw, rw;
  assign to  = cnt == CW'(MEM_TIMEOUT - 1);
  assign bad = funct3[2:1] == 2'b01;
  assign tk  = ~bad & ((funct3[2:1] == 2'b00 ? zero : funct3[2:1] == 2'b10 ? lt : ltu) ^ funct3[0]);
  always_comb begin
    case (state)
      FETCH:    nxt = mem_ready ? DECODE : to ? ERROR : FETCH;
      DECODE:   case (opcode)
                  7'b0110011:             nxt = EXEC_R;
                  7'b0010011:             nxt = EXEC_I;
                  7'b0000011, 7'b0100011: nxt = MEM_ADDR;
                  7'b1100011:             nxt = BRANCH;
                  7'b1101111:             nxt = JAL;
                  7'b1100111:             nxt = JALR;
                  default:                nxt = ERROR;
                endcase
      EXEC_R, EXEC_I: nxt = ALU_WB;
      MEM_ADDR: nxt = opcode == 7'b0000011 ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : to ? ERROR : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : to ? ERROR : MEM_WR;
      MEM_WB, ALU_WB, JAL, JALR: nxt = FETCH;
      BRANCH:   nxt = bad ? ERROR : FETCH;
      default:  nxt = ERROR;
    endcase
  end
  always_comb begin
    req = 1'b0;
    we = 1'b0;
    addr_src = 1'b0;
    pw = 1'b0;
    iw = 1'b0;
    rw = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        req = 1'b1;
        pw = mem_ready;
        iw = mem_ready;
        alu_src_b = 2'b10;
      end
      EXEC_R: {alu_src_a, alu_src_b, alu_op} = 6'b01_00_10;
      EXEC_I: {alu_src_a, alu_src_b, alu_op} = 6'b01_01_11;
      MEM_ADDR: {alu_src_a, alu_src_b, alu_op} = 6'b01_01_00;
      MEM_RD, MEM_WR: begin
        req = 1'b1;
        we = state == MEM_WR;
        addr_src = 1'b1;
      end
      MEM_WB: begin
        rw = 1'b1;
        result_src = 2'b01;
      end
      ALU_WB: rw = 1'b1;
      BRANCH: begin
        pw = tk;
        {alu_src_a, alu_src_b, alu_op} = tk ? 6'b10_01_00 : 6'b01_00_01;
      end
      JAL, JALR: begin
        rw = 1'b1;
        pw = 1'b1;
        result_src = 2'b10;
        alu_src_a = state == JAL ? 2'b10 : 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end
  assign mem_req   = req & ~rst;
  assign mem_we    = we & ~rst;
  assign pc_write  = pw & ~rst;
  assign ir_write  = iw & ~rst;
  assign reg_write = rw & ~rst;
  assign fault     = state == ERROR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt == state && req) ? cnt + CW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle checks plus multi-cycle corner sequences
module tb_multicycle_control;
  localparam logic [3:0] F = 4'd0, D = 4'd1, XR = 4'd2, XI = 4'd3, MA = 4'd4, MR = 4'd5,
                         MWB = 4'd6, MW = 4'd7, AWB = 4'd8, BR = 4'd9, JL = 4'd10, JR = 4'd11, ER = 4'd12;
  localparam logic [6:0] OR = 7'b0110011, OI = 7'b0010011, OL = 7'b0000011, OS = 7'b0100011,
                         OB = 7'b1100011, OJ = 7'b1101111, OJR = 7'b1100111, OX = 7'b1111111;
  logic clk = 0, rst = 1, zero = 0, lt = 0, ltu = 0, mem_ready = 0;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic mem_req, mem_we, addr_src, pc_write, ir_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic [18:0] act;
  int tests = 0, fails = 0;
  typedef struct {
    logic r;
    logic [6:0] opc;
    logic [2:0] f3;
    logic z, l, lu, rdy;
    logic [18:0] exp;
  } vec_t;
  vec_t q[$];
  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .state(state), .fault(fault)
  );
  always #5 clk = ~clk;
  assign act = {state, mem_req, mem_we, addr_src, pc_write, ir_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, fault};
  function automatic logic [18:0] e(input logic [3:0] st, input logic [5:0] en,
                                    input logic [7:0] sel, input logic f);
    return {st, en, sel, f};
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, x);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic r, input logic [6:0] o, input logic [2:0] f, input logic rd);
    rst = r;
    opcode = o;
    funct3 = f;
    mem_ready = rd;
  endtask
  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f, input logic z,
                     input logic l, input logic lu, input logic rd, input logic [18:0] x);
    q.push_back('{r, o, f, z, l, lu, rd, x});
  endtask
  task automatic reach_mem(input logic [6:0] o);
    set(0, o, 0, 1);
    tick;
    mem_ready = 0;
    tick;
    tick;
  endtask
  initial begin
    int n;
    // enables: mem_req,mem_we,addr_src,pc_write,ir_write,reg_write; sel: a,b,op,result_src
    add(1, OR, 0, 0, 0, 0, 0, e(F, 6'b000000, 8'b00_10_00_00, 0));
    add(0, OR, 0, 0, 0, 0, 0, e(F, 6'b100000, 8'b00_10_00_00, 0));
    add(0, OR, 0, 0, 0, 0, 0, e(F, 6'b100000, 8'b00_10_00_00, 0));
    add(0, OR, 0, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OR, 0, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OR, 0, 0, 0, 0, 0, e(XR, 6'b000000, 8'b01_00_10_00, 0));
    add(0, OR, 0, 0, 0, 0, 0, e(AWB, 6'b000001, 8'b00_00_00_00, 0));
    add(0, OL, 0, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OL, 0, 0, 0, 0, 1, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OL, 0, 0, 0, 0, 0, e(MA, 6'b000000, 8'b01_01_00_00, 0));
    add(0, OL, 0, 0, 0, 0, 1, e(MR, 6'b101000, 8'b00_00_00_00, 0));
    add(0, OL, 0, 0, 0, 0, 1, e(MWB, 6'b000001, 8'b00_00_00_01, 0));
    add(0, OB, 3'b000, 1, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OB, 3'b000, 1, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OB, 3'b000, 1, 0, 0, 0, e(BR, 6'b000100, 8'b10_01_00_00, 0));
    add(0, OB, 3'b000, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OB, 3'b000, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OB, 3'b000, 0, 0, 0, 0, e(BR, 6'b000000, 8'b01_00_01_00, 0));
    add(0, OJ, 0, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OJ, 0, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OJ, 0, 0, 0, 0, 0, e(JL, 6'b000101, 8'b10_01_00_10, 0));
    add(0, OJR, 0, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OJR, 0, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OJR, 0, 0, 0, 0, 0, e(JR, 6'b000101, 8'b01_01_00_10, 0));
    add(0, OI, 0, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OI, 0, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OI, 0, 0, 0, 0, 0, e(XI, 6'b000000, 8'b01_01_11_00, 0));
    add(0, OI, 0, 0, 0, 0, 0, e(AWB, 6'b000001, 8'b00_00_00_00, 0));
    add(0, OB, 3'b101, 0, 0, 1, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OB, 3'b101, 0, 0, 1, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OB, 3'b101, 0, 0, 1, 0, e(BR, 6'b000100, 8'b10_01_00_00, 0));
    add(0, OB, 3'b110, 0, 1, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OB, 3'b110, 0, 1, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OB, 3'b110, 0, 1, 0, 0, e(BR, 6'b000000, 8'b01_00_01_00, 0));
    add(0, OB, 3'b011, 0, 0, 0, 1, e(F, 6'b100110, 8'b00_10_00_00, 0));
    add(0, OB, 3'b011, 0, 0, 0, 0, e(D, 6'b000000, 8'b00_00_00_00, 0));
    add(0, OB, 3'b011, 0, 0, 0, 0, e(BR, 6'b000000, 8'b01_00_01_00, 0));
    add(0, OB, 3'b011, 0, 0, 0, 1, e(ER, 6'b000000, 8'b00_00_00_00, 1));
    tick;
    foreach (q[i]) begin
      rst = q[i].r;
      opcode = q[i].opc;
      funct3 = q[i].f3;
      zero = q[i].z;
      lt = q[i].l;
      ltu = q[i].lu;
      mem_ready = q[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d", i), 32'(act), 32'(q[i].exp));
      tick;
    end
    set(1, OX, 0, 0);
    tick;
    reach_mem(OX);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'(i);
      #1;
      chk($sformatf("err_stuck%0d", i), 32'(act), 32'(e(ER, 6'b000000, 8'b00_00_00_00, 1)));
      tick;
    end
    rst = 1;
    tick;
    chk("err_rst", 32'(act), 32'(e(F, 6'b000000, 8'b00_10_00_00, 0)));
    rst = 0;
    #1;
    chk("err_rst_req", 32'({mem_req, fault}), 32'b10);
    reach_mem(OS);
    chk("st_req", 32'({state, mem_req, mem_we, addr_src}), 32'({MW, 3'b111}));
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick;
    end
    chk("st_timeout_cycles", 32'(n), 32'd16);
    chk("st_timeout_err", 32'({state, mem_req, fault}), 32'({ER, 2'b01}));
    set(1, OL, 0, 0);
    tick;
    reach_mem(OL);
    repeat (15) tick;
    mem_ready = 1;
    #1;
    chk("ready_wins_pre", 32'({state, mem_req}), 32'({MR, 1'b1}));
    tick;
    mem_ready = 0;
    chk("ready_wins", 32'({state, reg_write, fault}), 32'({MWB, 2'b10}));
    set(1, OL, 0, 0);
    tick;
    reach_mem(OL);
    tick;
    tick;
    chk("midrd_pre", 32'({state, mem_req}), 32'({MR, 1'b1}));
    set(1, OL, 0, 1);
    tick;
    chk("midrd_rst", 32'({state, mem_req, reg_write, ir_write, pc_write}), 32'({F, 4'b0000}));
    set(0, OL, 0, 0);
    #1;
    chk("midrd_rel", 32'({state, mem_req, reg_write}), 32'({F, 2'b10}));
    tick;
    chk("midrd_fetch", 32'({state, mem_req, reg_write}), 32'({F, 2'b10}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
